// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_FAULT    = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the shared memory port and are guarded by the timer.
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: IR opcode / memory ready in, datapath controls and status out.
interface mcu_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                memto_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic                bus_error;
    logic [CNT_W-1:0]    retired;
    logic [3:0]          state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, bus_error, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, bus_error, retired, state
    );
endinterface

// File: rtl/multicycle_control_unit_wait_timer.sv
// Memory wait counter; expired flags the stall cycle that would reach MEM_TIMEOUT.
module mcu_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (incr)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = incr && (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main control FSM with memory timeout, illegal-opcode detect and retire count.
//   state    | meaning
//   IDLE     | post-reset, go fetch
//   FETCH    | read instruction, PC += 4 on ready
//   DECODE   | read regs, compute branch target, dispatch on opcode
//   MEM_ADDR | lw/sw effective address
//   MEM_RD   | data read            MEM_WB | load writeback
//   MEM_WR   | data write           R_EXEC / R_WB | R-type ALU / writeback
//   BRANCH   | beq compare          JUMP  | j
//   I_EXEC   | addi ALU             I_WB  | addi writeback
//   FAULT    | memory timeout, held until reset
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPCODE_W     = 6,
    parameter int MEM_TIMEOUT  = 16,
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst,
    mcu_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             bus_error_q, bus_error_d;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       memto_reg, reg_dst, reg_write, alu_src_a, illegal_op, retire;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       wait_incr, wait_clear, wait_expired;

    assign wait_incr  = is_wait_state(state_q) && !bus.mem_ready;
    assign wait_clear = (state_d != state_q);

    mcu_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .incr    (wait_incr),
        .expired (wait_expired)
    );

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        memto_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready)
                    state_d = S_DECODE;
                else if (wait_expired)
                    state_d = S_FAULT;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                if (bus.opcode == OPCODE_W'(OP_RTYPE))
                    state_d = S_R_EXEC;
                else if (bus.opcode == OPCODE_W'(OP_LW) || bus.opcode == OPCODE_W'(OP_SW))
                    state_d = S_MEM_ADDR;
                else if (bus.opcode == OPCODE_W'(OP_BEQ))
                    state_d = S_BRANCH;
                else if (bus.opcode == OPCODE_W'(OP_J))
                    state_d = S_JUMP;
                else if (SUPPORT_ADDI && bus.opcode == OPCODE_W'(OP_ADDI))
                    state_d = S_I_EXEC;
                else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                // IR is still held, so the opcode picks load versus store here.
                state_d   = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready)
                    state_d = S_MEM_WB;
                else if (wait_expired)
                    state_d = S_FAULT;
            end
            S_MEM_WB: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (wait_expired)
                    state_d = S_FAULT;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        retired_d   = retired_q + CNT_W'(retire);
        bus_error_d = bus_error_q | (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            retired_q   <= retired_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.memto_reg     = memto_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_source     = pc_source;
    assign bus.illegal_op    = illegal_op;
    assign bus.bus_error     = bus_error_q;
    assign bus.retired       = retired_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: instruction-level model queues per-cycle expectations, a monitor compares.
module tb_multicycle_control_unit;
    import mcu_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mcu_if #(.OPCODE_W(6), .CNT_W(32)) ifa ();
    mcu_if #(.OPCODE_W(6), .CNT_W(4))  ifb ();

    multicycle_control_unit #(.OPCODE_W(6), .MEM_TIMEOUT(16), .SUPPORT_ADDI(1'b1), .CNT_W(32))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    multicycle_control_unit #(.OPCODE_W(6), .MEM_TIMEOUT(4), .SUPPORT_ADDI(1'b0), .CNT_W(4))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    typedef struct {
        int          d;
        state_e      st;
        logic        rdy;
        logic        ill;
        logic        berr;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        state_e     st;
        logic       rdy;
        logic [5:0] op;
        logic       ill;
    } cyc_t;

    exp_t exp_q[$];
    cyc_t cyc_q[$];

    int          to_m[2]   = '{16, 4};
    bit          addi_m[2] = '{1'b1, 1'b0};
    logic [31:0] mask_m[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    logic [31:0] cnt_m[2]  = '{32'd0, 32'd0};
    bit          berr_m[2] = '{1'b0, 1'b0};
    bit          fault_f;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mk(input bit pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                                       input logic [1:0] sb, ao, ps);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, sb, ao, ps};
    endfunction

    // Control word each state must present, straight from the state/control table.
    function automatic logic [15:0] exp_ctrl(state_e st, logic rdy);
        case (st)
            S_FETCH:    return mk(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
            S_DECODE:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
            S_MEM_ADDR: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
            S_MEM_RD:   return mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
            S_MEM_WB:   return mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
            S_MEM_WR:   return mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
            S_R_EXEC:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
            S_R_WB:     return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
            S_BRANCH:   return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
            S_JUMP:     return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
            S_I_EXEC:   return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
            S_I_WB:     return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
            default:    return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] act_ctrl(int d);
        if (d == 0)
            return {ifa.pc_write, ifa.pc_write_cond, ifa.i_or_d, ifa.mem_read, ifa.mem_write,
                    ifa.ir_write, ifa.memto_reg, ifa.reg_dst, ifa.reg_write, ifa.alu_src_a,
                    ifa.alu_src_b, ifa.alu_op, ifa.pc_source};
        return {ifb.pc_write, ifb.pc_write_cond, ifb.i_or_d, ifb.mem_read, ifb.mem_write,
                ifb.ir_write, ifb.memto_reg, ifb.reg_dst, ifb.reg_write, ifb.alu_src_a,
                ifb.alu_src_b, ifb.alu_op, ifb.pc_source};
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut=%0d t=%0t got=%h expected=%h", name, d, $time, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.d == 0) begin
                    chk("state", 0, 32'(ifa.state), 32'(e.st));
                    chk("illegal_op", 0, 32'(ifa.illegal_op), 32'(e.ill));
                    chk("bus_error", 0, 32'(ifa.bus_error), 32'(e.berr));
                    chk("retired", 0, ifa.retired, e.ret);
                end else begin
                    chk("state", 1, 32'(ifb.state), 32'(e.st));
                    chk("illegal_op", 1, 32'(ifb.illegal_op), 32'(e.ill));
                    chk("bus_error", 1, 32'(ifb.bus_error), 32'(e.berr));
                    chk("retired", 1, 32'(ifb.retired), e.ret);
                end
                chk("controls", e.d, 32'(act_ctrl(e.d)), 32'(exp_ctrl(e.st, e.rdy)));
            end
        end
    end

    task automatic drive_cycle(int d, bit r, cyc_t c);
        exp_t e;
        @(posedge clk);
        #1;
        if (d == 0) begin
            rst_a = r; ifa.mem_ready = c.rdy; ifa.opcode = c.op;
        end else begin
            rst_b = r; ifb.mem_ready = c.rdy; ifb.opcode = c.op;
        end
        if (r) begin
            cnt_m[d]  = 32'd0;
            berr_m[d] = 1'b0;
        end
        if (c.st == S_FAULT) berr_m[d] = 1'b1;
        e.d = d; e.st = c.st; e.rdy = c.rdy; e.ill = c.ill;
        e.berr = berr_m[d]; e.ret = cnt_m[d] & mask_m[d];
        exp_q.push_back(e);
    endtask

    task automatic do_reset(int d);
        cyc_t c;
        c.st = S_IDLE; c.rdy = 1'b0; c.op = 6'($urandom); c.ill = 1'b0;
        drive_cycle(d, 1'b1, c);
        drive_cycle(d, 1'b0, c);
    endtask

    task automatic push_c(state_e st, logic [5:0] op, logic ill);
        cyc_t c;
        c.st = st; c.rdy = 1'($urandom); c.op = op; c.ill = ill;
        cyc_q.push_back(c);
    endtask

    // n not-ready cycles then the completing one; the n-th consecutive stall
    // that reaches the timeout diverts to FAULT instead.
    task automatic add_wait(int d, state_e st, int n, logic [5:0] op);
        cyc_t c;
        c.st = st; c.ill = 1'b0;
        for (int i = 0; i < n; i++) begin
            c.rdy = 1'b0;
            c.op  = (st == S_FETCH) ? 6'($urandom) : op;
            cyc_q.push_back(c);
            if (i + 1 == to_m[d]) begin
                fault_f = 1'b1;
                return;
            end
        end
        c.rdy = 1'b1;
        c.op  = (st == S_FETCH) ? 6'($urandom) : op;
        cyc_q.push_back(c);
    endtask

    task automatic run_instr(int d, logic [5:0] op, int sf, int sm, int abort);
        bit retires;
        int n;
        cyc_q.delete();
        fault_f = 1'b0;
        retires = 1'b1;
        add_wait(d, S_FETCH, sf, op);
        if (!fault_f) begin
            if (op == OP_RTYPE) begin
                push_c(S_DECODE, op, 0); push_c(S_R_EXEC, op, 0); push_c(S_R_WB, op, 0);
            end else if (op == OP_LW) begin
                push_c(S_DECODE, op, 0); push_c(S_MEM_ADDR, op, 0);
                add_wait(d, S_MEM_RD, sm, op);
                if (!fault_f) push_c(S_MEM_WB, op, 0);
            end else if (op == OP_SW) begin
                push_c(S_DECODE, op, 0); push_c(S_MEM_ADDR, op, 0);
                add_wait(d, S_MEM_WR, sm, op);
            end else if (op == OP_BEQ) begin
                push_c(S_DECODE, op, 0); push_c(S_BRANCH, op, 0);
            end else if (op == OP_J) begin
                push_c(S_DECODE, op, 0); push_c(S_JUMP, op, 0);
            end else if (op == OP_ADDI && addi_m[d]) begin
                push_c(S_DECODE, op, 0); push_c(S_I_EXEC, op, 0); push_c(S_I_WB, op, 0);
            end else begin
                push_c(S_DECODE, op, 1);
                retires = 1'b0;
            end
        end
        if (fault_f) begin
            retires = 1'b0;
            repeat (3) push_c(S_FAULT, 6'($urandom), 0);
        end
        n = (abort > 0) ? abort : cyc_q.size();
        for (int i = 0; i < n; i++) drive_cycle(d, 1'b0, cyc_q[i]);
        if (abort > 0)
            do_reset(d);
        else if (retires)
            cnt_m[d] = cnt_m[d] + 32'd1;
    endtask

    function automatic logic [5:0] pick_op(bit legal_only);
        logic [5:0] ops[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        logic [5:0] o;
        int k;
        k = legal_only ? $urandom_range(0, 4) : $urandom_range(0, 6);
        if (k < 6) return ops[k];
        do o = 6'($urandom);
        while (o == OP_RTYPE || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J || o == OP_ADDI);
        return o;
    endfunction

    function automatic int pick_stall(int d);
        if ($urandom_range(0, 7) == 0) return to_m[d] - 1;
        return $urandom_range(0, 2);
    endfunction

    initial begin : stimulus
        ifa.opcode = '0; ifa.mem_ready = 1'b0;
        ifb.opcode = '0; ifb.mem_ready = 1'b0;

        do_reset(0);
        run_instr(0, OP_RTYPE, 0, 0, 0);
        run_instr(0, OP_LW, 0, 2, 0);
        run_instr(0, OP_BEQ, 0, 0, 0);
        run_instr(0, OP_J, 0, 0, 0);
        run_instr(0, OP_SW, 0, 0, 0);
        run_instr(0, OP_ADDI, 0, 0, 0);
        run_instr(0, 6'b111111, 0, 0, 0);
        run_instr(0, OP_SW, 1, 15, 0);
        repeat (40) run_instr(0, pick_op(1'b0), pick_stall(0), pick_stall(0), 0);
        run_instr(0, OP_SW, 0, 3, 5);
        run_instr(0, OP_RTYPE, 0, 0, 0);
        run_instr(0, OP_LW, 0, 16, 0);
        do_reset(0);
        run_instr(0, OP_J, 0, 0, 0);

        do_reset(1);
        run_instr(1, 6'b111111, 0, 0, 0);
        run_instr(1, OP_ADDI, 0, 0, 0);
        run_instr(1, OP_RTYPE, 3, 0, 0);
        run_instr(1, OP_BEQ, 4, 0, 0);
        do_reset(1);
        repeat (20) run_instr(1, pick_op(1'b1), pick_stall(1), pick_stall(1), 0);
        run_instr(1, OP_SW, 0, 4, 0);
        do_reset(1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
